// File: rtl/raster_pkg.sv
// Shared types for the raster address generator: per-axis count direction
// and end-of-frame behaviour.
package raster_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {MODE_STOP = 1'b0, MODE_WRAP = 1'b1} wrap_e;

endpackage

// File: rtl/axis_counter.sv
// One raster axis: counts 0..N-1 up or N-1..0 down, reloading its start value
// on load or when stepped past its terminal value.
module axis_counter
  import raster_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int N     = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  dir_e             dir,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value,
  output logic             at_terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] start_value;
  logic [WIDTH-1:0] terminal_value;

  function automatic logic [WIDTH-1:0] stepped(input logic [WIDTH-1:0] v, input dir_e d);
    return (d == DIR_DOWN) ? v - ONE : v + ONE;
  endfunction

  assign start_value    = (dir == DIR_DOWN) ? LAST : ZERO;
  assign terminal_value = (dir == DIR_DOWN) ? ZERO : LAST;
  // Explicit terminal compare keeps non-power-of-two ranges from wrapping through 2**WIDTH.
  assign at_terminal    = (value == terminal_value);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= ZERO;
    end else if (load) begin
      value <= start_value;
    end else if (step) begin
      value <= at_terminal ? start_value : stepped(value, dir);
    end
  end

endmodule

// File: rtl/raster_addr_counter.sv
// Two-axis raster address generator: column carries into row, with line/frame
// completion pulses and wrap or stop-at-end behaviour latched on clear.
module raster_addr_counter
  import raster_pkg::*;
#(
  parameter int COL_WIDTH = 10,
  parameter int ROW_WIDTH = 10,
  parameter int NUM_COLS  = 1024,
  parameter int NUM_ROWS  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 col_dir,
  input  logic                 row_dir,
  input  logic                 wrap_mode,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 line_done,
  output logic                 frame_done,
  output logic                 halted
);

  dir_e  col_dir_q;
  dir_e  row_dir_q;
  wrap_e wrap_q;
  dir_e  col_dir_sel;
  dir_e  row_dir_sel;
  logic  col_term;
  logic  row_term;
  logic  advance;
  logic  frame_end;
  logic  stop_here;
  logic  col_step;
  logic  row_step;

  // On clear the incoming directions drive the start-value load directly.
  assign col_dir_sel = clear ? dir_e'(col_dir) : col_dir_q;
  assign row_dir_sel = clear ? dir_e'(row_dir) : row_dir_q;

  assign advance   = enable && !halted && !clear;
  assign frame_end = col_term && row_term;
  assign stop_here = frame_end && (wrap_q == MODE_STOP);
  assign col_step  = advance && !stop_here;
  assign row_step  = advance && col_term && !stop_here;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_dir_q <= DIR_UP;
      row_dir_q <= DIR_UP;
      wrap_q    <= MODE_WRAP;
    end else if (clear) begin
      col_dir_q <= dir_e'(col_dir);
      row_dir_q <= dir_e'(row_dir);
      wrap_q    <= wrap_e'(wrap_mode);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      halted     <= 1'b0;
    end else if (clear) begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      halted     <= 1'b0;
    end else begin
      line_done  <= advance && col_term;
      frame_done <= advance && frame_end;
      halted     <= halted || (advance && stop_here);
    end
  end

  axis_counter #(
    .WIDTH(COL_WIDTH),
    .N    (NUM_COLS)
  ) u_col (
    .clk        (clk),
    .reset      (reset),
    .dir        (col_dir_sel),
    .load       (clear),
    .step       (col_step),
    .value      (col),
    .at_terminal(col_term)
  );

  axis_counter #(
    .WIDTH(ROW_WIDTH),
    .N    (NUM_ROWS)
  ) u_row (
    .clk        (clk),
    .reset      (reset),
    .dir        (row_dir_sel),
    .load       (clear),
    .step       (row_step),
    .value      (row),
    .at_terminal(row_term)
  );

endmodule
